// File: rtl/dense_layer_1_ctrl.sv
// Sequencer for a time-multiplexed dense layer: walks every output neuron over
// all input elements, drives ROM addresses and MAC/bias/write strobes, and
// reports one done pulse per complete layer pass.
module dense_layer_1_ctrl #(
  parameter int unsigned IN_SIZE  = 26,
  parameter int unsigned OUT_SIZE = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned IN_W     = $clog2(IN_SIZE),
  parameter int unsigned OUT_W    = $clog2(OUT_SIZE),
  parameter int unsigned W_W      = $clog2(IN_SIZE * OUT_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [IN_W-1:0]  in_sel,
  output logic [W_W-1:0]   w_addr,
  output logic [OUT_W-1:0] b_addr,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             bias_en,
  output logic             out_we,
  output logic [OUT_W-1:0] out_idx
);

  localparam int unsigned RD_CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_BIAS  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    in_sel_q, in_sel_d;
  logic [OUT_W-1:0]   out_idx_q, out_idx_d;
  logic [RD_CW-1:0]   drain_q, drain_d;
  logic [RD_LAT-1:0]  pipe_q, pipe_d;
  logic [W_W-1:0]     w_addr_q, w_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mac_clr_q, mac_clr_d;
  logic               bias_en_q, bias_en_d;
  logic               out_we_q, out_we_d;
  logic               kill;

  // Next state, counters, issue-delay pipe and registered output values
  always_comb begin
    state_d   = state_q;
    in_sel_d  = in_sel_q;
    out_idx_d = out_idx_q;
    drain_d   = drain_q;
    kill      = abort && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        in_sel_d  = '0;
        out_idx_d = '0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: state_d = S_MAC;
      S_MAC: begin
        if (in_sel_q == IN_W'(IN_SIZE - 1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          in_sel_d = in_sel_q + IN_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == RD_CW'(RD_LAT - 1)) state_d = S_BIAS;
        else                               drain_d = drain_q + RD_CW'(1);
      end
      S_BIAS: state_d = S_WRITE;
      S_WRITE: begin
        if (out_idx_q == OUT_W'(OUT_SIZE - 1)) begin
          state_d = S_DONE;
        end else begin
          out_idx_d = out_idx_q + OUT_W'(1);
          in_sel_d  = '0;
          state_d   = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        in_sel_d  = '0;
        out_idx_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Issue strobe travels RD_LAT stages so mac_en lines up with ROM data
    pipe_d[0] = (state_q == S_MAC);
    for (int i = 1; i < int'(RD_LAT); i++) pipe_d[i] = pipe_q[i-1];

    if (kill) begin
      state_d   = S_IDLE;
      in_sel_d  = '0;
      out_idx_d = '0;
      drain_d   = '0;
      pipe_d    = '0;
    end

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    mac_clr_d = (state_d == S_CLEAR);
    bias_en_d = (state_d == S_BIAS);
    out_we_d  = (state_d == S_WRITE);
    w_addr_d  = W_W'(out_idx_d) * W_W'(IN_SIZE) + W_W'(in_sel_d);
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_sel_q  <= '0;
      out_idx_q <= '0;
      drain_q   <= '0;
      pipe_q    <= '0;
      w_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mac_clr_q <= 1'b0;
      bias_en_q <= 1'b0;
      out_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_sel_q  <= in_sel_d;
      out_idx_q <= out_idx_d;
      drain_q   <= drain_d;
      pipe_q    <= pipe_d;
      w_addr_q  <= w_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mac_clr_q <= mac_clr_d;
      bias_en_q <= bias_en_d;
      out_we_q  <= out_we_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign in_sel  = in_sel_q;
  assign w_addr  = w_addr_q;
  assign b_addr  = out_idx_q;
  assign out_idx = out_idx_q;
  assign mac_clr = mac_clr_q;
  assign mac_en  = pipe_q[RD_LAT-1];
  assign bias_en = bias_en_q;
  assign out_we  = out_we_q;

endmodule

// File: tb/tb_dense_layer_1_ctrl.sv
// Directed bench for dense_layer_1_ctrl: default build plus an RD_LAT=3 build,
// each compared cycle by cycle against a phase-based model of a layer pass.
module tb_dense_layer_1_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build (RD_LAT=1)
  logic rst0, start0, abort0;
  logic busy0, done0, clr0, men0, ben0, we0;
  logic [4:0] isel0, oidx0, baddr0;
  logic [9:0] waddr0;

  // RD_LAT=3 build
  logic rst3, start3, abort3;
  logic busy3, done3, clr3, men3, ben3, we3;
  logic [4:0] isel3, oidx3, baddr3;
  logic [9:0] waddr3;

  dense_layer_1_ctrl u0 (
    .clk(clk), .rst(rst0), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .in_sel(isel0), .w_addr(waddr0),
    .b_addr(baddr0), .mac_clr(clr0), .mac_en(men0), .bias_en(ben0),
    .out_we(we0), .out_idx(oidx0)
  );

  dense_layer_1_ctrl #(.RD_LAT(3)) u3 (
    .clk(clk), .rst(rst3), .start(start3), .abort(abort3),
    .busy(busy3), .done(done3), .in_sel(isel3), .w_addr(waddr3),
    .b_addr(baddr3), .mac_clr(clr3), .mac_en(men3), .bias_en(ben3),
    .out_we(we3), .out_idx(oidx3)
  );

  int total = 0;
  int bad   = 0;
  int n_clr, n_men, n_ben, n_we, n_done, done_at;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // {busy,done,mac_clr,mac_en,bias_en,out_we,in_sel,out_idx,b_addr,w_addr}
  function automatic logic [30:0] obs0();
    return {busy0, done0, clr0, men0, ben0, we0, isel0, oidx0, baddr0, waddr0};
  endfunction

  function automatic logic [30:0] obs3();
    return {busy3, done3, clr3, men3, ben3, we3, isel3, oidx3, baddr3, waddr3};
  endfunction

  // Expected outputs in cycle c of a pass (c=1 is the CLEAR after start)
  function automatic logic [30:0] expv(input int lat, input int c);
    int per, n, p, isel, oidx, wa;
    logic b, d, cl, me, be, we;
    per = 26 + lat + 3;
    b = 0; d = 0; cl = 0; me = 0; be = 0; we = 0; isel = 0; oidx = 0;
    if (c >= 1 && c <= 32 * per) begin
      n    = (c - 1) / per;
      p    = (c - 1) % per;
      b    = 1;
      oidx = n;
      isel = (p == 0) ? 0 : ((p <= 26) ? p - 1 : 25);
      cl   = (p == 0);
      me   = (p >= 1 + lat) && (p <= 26 + lat);
      be   = (p == 27 + lat);
      we   = (p == 28 + lat);
    end else if (c == 32 * per + 1) begin
      b = 1; d = 1; oidx = 31; isel = 25;
    end
    wa = oidx * 26 + isel;
    return {b, d, cl, me, be, we, 5'(isel), 5'(oidx), 5'(oidx), 10'(wa)};
  endfunction

  // Compare cycles c0..c1 of a pass against the model, tallying strobes
  task automatic trace(input int lat, input int c0, input int c1);
    logic [30:0] v;
    for (int c = c0; c <= c1; c++) begin
      v = (lat == 3) ? obs3() : obs0();
      if (v[28]) n_clr++;
      if (v[27]) n_men++;
      if (v[26]) n_ben++;
      if (v[25]) n_we++;
      if (v[29]) begin n_done++; done_at = c; end
      check($sformatf("trace L%0d cyc%0d", lat, c), 32'(v), 32'(expv(lat, c)));
      step();
    end
  endtask

  task automatic clear_tally();
    n_clr = 0; n_men = 0; n_ben = 0; n_we = 0; n_done = 0; done_at = -1;
  endtask

  initial begin
    rst0 = 1; start0 = 1; abort0 = 0;
    rst3 = 1; start3 = 0; abort3 = 0;

    // Reset held with start high: everything stays zero
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset hold %0d", i), 32'(obs0()), 32'd0);
    end
    rst0 = 0; start0 = 0; rst3 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle after reset %0d", i), 32'(obs0()), 32'd0);
    end

    // Single pass from a one-cycle start pulse
    start0 = 1;
    step();
    start0 = 0;
    clear_tally();
    trace(1, 1, 962);
    check("pass1 mac_en count", 32'(n_men), 32'd832);
    check("pass1 out_we count", 32'(n_we), 32'd32);
    check("pass1 mac_clr count", 32'(n_clr), 32'd32);
    check("pass1 bias_en count", 32'(n_ben), 32'd32);
    check("pass1 done count", 32'(n_done), 32'd1);
    check("pass1 done cycle", 32'(done_at), 32'd961);

    // Start held high: back-to-back passes with one IDLE cycle in between
    start0 = 1;
    step();
    trace(1, 1, 962);
    check("b2b next clear", 32'(obs0()), 32'(expv(1, 1)));
    step();
    trace(1, 2, 161);
    start0 = 0;

    // Abort during neuron 5 MAC at in_sel=10
    check("pre-abort in_sel", 32'(isel0), 32'd10);
    check("pre-abort out_idx", 32'(oidx0), 32'd5);
    abort0 = 1;
    step();
    abort0 = 0;
    check("abort to idle", 32'(obs0()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post-abort quiet %0d", i), 32'(obs0()), 32'd0);
    end

    // Start and abort together in IDLE: start wins, full pass from neuron 0
    start0 = 1; abort0 = 1;
    step();
    start0 = 0; abort0 = 0;
    clear_tally();
    trace(1, 1, 962);
    check("pass3 done cycle", 32'(done_at), 32'd961);
    check("pass3 out_we count", 32'(n_we), 32'd32);

    // RD_LAT=3 build: 32-cycle neurons, done at 1025
    start3 = 1;
    step();
    start3 = 0;
    clear_tally();
    trace(3, 1, 1026);
    check("L3 done cycle", 32'(done_at), 32'd1025);
    check("L3 mac_en count", 32'(n_men), 32'd832);

    // Reset landing mid-DRAIN clears everything on that edge
    start3 = 1;
    step();
    start3 = 0;
    trace(3, 1, 28);
    check("L3 mid-drain mac_en", 32'(men3), 32'd1);
    rst3 = 1;
    step();
    check("L3 reset mid-drain", 32'(obs3()), 32'd0);
    rst3 = 0;
    step();
    check("L3 idle after reset", 32'(obs3()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_layer_1_ctrl.md
Name: dense_layer_1_ctrl

Overview:
Sequencer for a time-multiplexed first dense layer (26 inputs, 32 neurons, 16-bit inputs, 24-bit accumulators). It walks each output neuron over all input elements and drives weight/bias ROM addresses, the input-element select and the MAC/bias/write strobes. It runs one full layer pass per start request and signals completion to the top-level inference FSM.

Parameters:
IN_SIZE, 26, input vector length (MAC steps per neuron)
OUT_SIZE, 32, number of output neurons
RD_LAT, 1, weight/bias ROM read latency in cycles (1..4)
IN_W, $clog2(IN_SIZE), width of in_sel
OUT_W, $clog2(OUT_SIZE), width of out_idx/b_addr
W_W, $clog2(IN_SIZE*OUT_SIZE), width of w_addr

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request one layer pass; sampled only in IDLE
abort  in  1  synchronous abort; ignored in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of a complete pass
in_sel  out  IN_W  input_vector element index for current weight
w_addr  out  W_W  weight ROM address = out_idx*IN_SIZE + in_sel
b_addr  out  OUT_W  bias ROM address (= out_idx)
mac_clr  out  1  clear accumulator
mac_en  out  1  accumulate weight*input (ROM data valid)
bias_en  out  1  add bias to accumulator
out_we  out  1  write accumulator to output_vector[out_idx]
out_idx  out  OUT_W  current neuron index

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; mac_en delay pipe cleared. Reset mid-pass takes effect on that edge; no done.
- All outputs registered (Moore on registered state/counters).
- States: IDLE, CLEAR, MAC, DRAIN, BIAS, WRITE, DONE.
- IDLE: start=1 -> CLEAR; out_idx=0, in_sel=0.
- CLEAR: 1 cycle, mac_clr=1 -> MAC.
- MAC: IN_SIZE cycles; w_addr issued with in_sel 0..IN_SIZE-1, one per cycle; in_sel increments every cycle; at in_sel=IN_SIZE-1 -> DRAIN.
- mac_en = MAC-issue strobe delayed RD_LAT cycles through a shift register; exactly IN_SIZE high cycles per neuron, contiguous.
- DRAIN: RD_LAT cycles (last mac_en lands here) -> BIAS.
- BIAS: 1 cycle, bias_en=1 (b_addr stable since CLEAR, so data valid for RD_LAT<=IN_SIZE+1) -> WRITE.
- WRITE: 1 cycle, out_we=1 with out_idx of finished neuron. If out_idx=OUT_SIZE-1 -> DONE, else out_idx+1, in_sel=0 -> CLEAR.
- DONE: 1 cycle, done=1, busy=1 -> IDLE.
- Per-neuron cycles: IN_SIZE+RD_LAT+3 (30 default). Start accepted at edge k: CLEAR in cycle k+1, done in cycle k+1+OUT_SIZE*(IN_SIZE+RD_LAT+3) = k+961 default; IDLE again at k+962.
- Strobes mac_clr, mac_en, bias_en, out_we mutually exclusive in any cycle.
- start while not IDLE (including DONE cycle) ignored; no queuing.
- abort (non-IDLE): next edge -> IDLE, all strobes 0, delay pipe flushed, done not pulsed, out_idx/in_sel to 0. abort and start same cycle in IDLE: start wins (abort ignored in IDLE). rst overrides abort and start.
- No wrap: counters never exceed IN_SIZE-1 / OUT_SIZE-1; w_addr max = IN_SIZE*OUT_SIZE-1 (831).

Test Plan:
- Reset: hold rst 3 cycles with start=1 -> all outputs 0, busy=0; release -> stays IDLE until start sampled with rst=0.
- Single pass defaults: 1-cycle start pulse at edge k -> done exactly at cycle k+961, one cycle wide; 32 out_we pulses with out_idx 0..31; 832 mac_en cycles; 32 mac_clr and 32 bias_en.
- Address sequence: neuron 0 w_addr 0..25 consecutive, neuron 31 w_addr 806..831; mac_en rises 1 cycle after first w_addr of each neuron; b_addr=out_idx throughout.
- start held high continuously -> passes back-to-back with one IDLE cycle between done and next CLEAR; start pulses mid-pass produce no extra pass.
- abort during neuron 5 MAC (in_sel=10) -> next cycle IDLE, busy=0, no further mac_en/out_we, no done; new start then runs a full 961-cycle pass from out_idx 0.
- RD_LAT=3 build: per-neuron 32 cycles, done at k+1025; mac_en lags w_addr by 3 cycles; reset asserted mid-DRAIN -> outputs 0 on that edge.
